multichannel_tap_line: RTL

Parametrised successor to the single-channel tap shift line. It keeps NUM_CH independent tap lines of TOTAL_TAPS signed elements each, time-multiplexed on one input stream selected by i_ch, and tracks fill level per channel. It supports per-channel flush, two strobe modes, and optional gating of the calculation start until a line is full. It sits between the sample source and the shared FIR/rolling-average engine, which consumes o_taps when o_start_calc pulses.

---
 rtl/multichannel_tap_line.sv | 113 +++++++++++
 1 files changed

// File: rtl/multichannel_tap_line.sv
// rtl/multichannel_tap_line.sv - per-channel signed tap shift lines multiplexed on one sample stream
// Each accepted sample shifts one channel's line; the updated line is presented to the shared engine.
module multichannel_tap_line #(
  parameter int NUM_CH          = 4,
  parameter int CH_BITS         = 2,
  parameter int TOTAL_TAPS      = 8,
  parameter int BITS_PER_ELEM   = 5,
  parameter int STROBE_MODE     = 1,
  parameter int GATE_UNTIL_FULL = 0
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic signed [BITS_PER_ELEM-1:0]       i_value,
  input  logic [CH_BITS-1:0]                    i_ch,
  input  logic                                  i_data_clk,
  input  logic                                  i_flush,
  input  logic [CH_BITS-1:0]                    i_flush_ch,
  output logic [TOTAL_TAPS*BITS_PER_ELEM-1:0]   o_taps,
  output logic                                  o_start_calc,
  output logic [CH_BITS-1:0]                    o_calc_ch,
  output logic [$clog2(TOTAL_TAPS+1)-1:0]       o_fill,
  output logic [NUM_CH-1:0]                     o_full,
  output logic                                  o_err_ch
);
  localparam int TOTAL_BITS = TOTAL_TAPS * BITS_PER_ELEM;
  localparam int FILL_W     = $clog2(TOTAL_TAPS + 1);
  localparam logic [FILL_W-1:0]  FILL_MAX = FILL_W'(TOTAL_TAPS);
  localparam logic [CH_BITS:0]   NUM_CH_W = (CH_BITS + 1)'(NUM_CH);

  logic [TOTAL_BITS-1:0] r_line [NUM_CH];
  logic [FILL_W-1:0]     r_fill [NUM_CH];
  logic                  r_dclk_d1;
  logic                  r_dclk_d2;
  logic                  r_armed;

  logic                  w_accept;
  logic                  w_ch_ok;
  logic                  w_flush_ok;
  logic                  w_flush_hit;
  logic                  w_shift;
  logic [TOTAL_BITS-1:0] w_sel_line;
  logic [TOTAL_BITS-1:0] w_new_line;
  logic [FILL_W-1:0]     w_sel_fill;
  logic [FILL_W-1:0]     w_new_fill;

  // r_armed blocks a strobe that was already high when reset released
  assign w_accept    = (STROBE_MODE != 0) ? (i_data_clk & ~r_dclk_d1 & ~r_dclk_d2 & r_armed)
                                          : i_data_clk;
  assign w_ch_ok     = {1'b0, i_ch} < NUM_CH_W;
  assign w_flush_ok  = i_flush & ({1'b0, i_flush_ch} < NUM_CH_W);
  assign w_flush_hit = w_flush_ok & (i_flush_ch == i_ch);
  assign w_shift     = w_accept & w_ch_ok & ~w_flush_hit;

  always_comb begin
    w_sel_line = '0;
    w_sel_fill = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (i_ch == CH_BITS'(c)) begin
        w_sel_line = r_line[c];
        w_sel_fill = r_fill[c];
      end
    end
  end

  assign w_new_line = {w_sel_line[TOTAL_BITS-BITS_PER_ELEM-1:0], i_value};
  assign w_new_fill = (w_sel_fill == FILL_MAX) ? FILL_MAX : w_sel_fill + FILL_W'(1);

  always_comb begin
    o_full = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      o_full[c] = (r_fill[c] == FILL_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_line[c] <= '0;
        r_fill[c] <= '0;
      end
      r_dclk_d1    <= 1'b0;
      r_dclk_d2    <= 1'b0;
      r_armed      <= ~i_data_clk;
      o_taps       <= '0;
      o_start_calc <= 1'b0;
      o_calc_ch    <= '0;
      o_fill       <= '0;
      o_err_ch     <= 1'b0;
    end else begin
      r_dclk_d1    <= i_data_clk;
      r_dclk_d2    <= r_dclk_d1;
      if (!i_data_clk) r_armed <= 1'b1;
      o_err_ch     <= w_accept & ~w_ch_ok;
      o_start_calc <= 1'b0;
      // Flush beats a same-channel shift; different channels proceed independently
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_flush_ok && i_flush_ch == CH_BITS'(c)) begin
          r_line[c] <= '0;
          r_fill[c] <= '0;
        end else if (w_shift && i_ch == CH_BITS'(c)) begin
          r_line[c] <= w_new_line;
          r_fill[c] <= w_new_fill;
        end
      end
      if (w_shift) begin
        o_taps       <= w_new_line;
        o_calc_ch    <= i_ch;
        o_fill       <= w_new_fill;
        o_start_calc <= (GATE_UNTIL_FULL == 0) || (w_new_fill == FILL_MAX);
      end
    end
  end
endmodule
